// File: rtl/fetch_pc_sequencer.sv
// Fetch-block / instruction-PC sequencer for a FETCH_BYTES-wide sync BRAM.
// Compressed (16-bit) parcel support: define FROST_FETCH_SEQ_COMPRESSED_EN.
module fetch_pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     FETCH_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_stall,
    input  logic                     i_redirect_valid,
    input  logic [XLEN-1:0]          i_redirect_target,
    input  logic [FETCH_BYTES*8-1:0] i_fetch_data,
    output logic [XLEN-1:0]          o_fetch_pc,
    output logic                     o_instr_valid,
    output logic [31:0]              o_instr,
    output logic [XLEN-1:0]          o_instr_pc,
    output logic                     o_is_compressed,
    output logic                     o_spanning
);

    localparam int unsigned OB   = $clog2(FETCH_BYTES);
    localparam int unsigned OFFW = OB - 1;
    localparam int unsigned P    = FETCH_BYTES / 2;

    localparam logic [XLEN-1:0] BLK_MASK = ~(XLEN'(FETCH_BYTES - 1));
    localparam logic [XLEN-1:0] BLK_STEP = XLEN'(FETCH_BYTES);
    localparam logic [OFFW-1:0] OFF_PAIR = OFFW'(P - 2);

`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
    localparam logic [XLEN-1:0] PC_MASK  = ~(XLEN'(1));
    localparam logic [OFFW-1:0] OFF_LAST = OFFW'(P - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        SPAN = 2'd2
    } state_t;
`else
    localparam logic [XLEN-1:0] PC_MASK  = ~(XLEN'(3));

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1
    } state_t;
`endif

    state_t          state_r;
    state_t          state_d;
    logic [XLEN-1:0] blk_r;
    logic [XLEN-1:0] blk_d;
    logic [XLEN-1:0] instr_pc_r;
    logic [XLEN-1:0] instr_pc_d;
    logic [OFFW-1:0] off;
    logic [OFFW-1:0] off_hi;
    logic [15:0]     lo;
    logic [15:0]     hi;
    logic [XLEN-1:0] tgt_blk;
    logic [XLEN-1:0] tgt_pc;
    logic            fetch_adv;

`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
    logic [15:0]     span_lo_r;
    logic [15:0]     span_lo_d;
`endif

    assign off     = instr_pc_r[OB-1:1];
    assign off_hi  = off + OFFW'(1);
    assign lo      = i_fetch_data[{off, 4'h0} +: 16];
    assign hi      = i_fetch_data[{off_hi, 4'h0} +: 16];
    assign tgt_blk = i_redirect_target & BLK_MASK;
    assign tgt_pc  = i_redirect_target & PC_MASK;

    assign o_instr_pc = instr_pc_r;
    assign o_fetch_pc = blk_d;

`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
    assign o_spanning = (state_r == SPAN);
`else
    assign o_spanning = 1'b0;
`endif

    // Next-state, parcel extraction and emit; redirect beats stall.
    always_comb begin
        state_d         = state_r;
        blk_d           = blk_r;
        instr_pc_d      = instr_pc_r;
`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
        span_lo_d       = span_lo_r;
`endif
        fetch_adv       = 1'b0;
        o_instr_valid   = 1'b0;
        o_instr         = {hi, lo};
        o_is_compressed = 1'b0;

        unique case (state_r)
            BOOT: state_d = RUN;
            RUN: begin
`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
                if (lo[1:0] != 2'b11) begin
                    o_instr_valid   = 1'b1;
                    o_instr         = {16'h0, lo};
                    o_is_compressed = 1'b1;
                    instr_pc_d      = instr_pc_r + XLEN'(2);
                    fetch_adv       = (off == OFF_LAST);
                end else if (off != OFF_LAST) begin
                    o_instr_valid = 1'b1;
                    instr_pc_d    = instr_pc_r + XLEN'(4);
                    fetch_adv     = (off == OFF_PAIR);
                end else begin
                    span_lo_d = lo;
                    state_d   = SPAN;
                    fetch_adv = 1'b1;
                end
`else
                o_instr_valid = 1'b1;
                instr_pc_d    = instr_pc_r + XLEN'(4);
                fetch_adv     = (off == OFF_PAIR);
`endif
            end
`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
            SPAN: begin
                o_instr_valid = 1'b1;
                o_instr       = {i_fetch_data[15:0], span_lo_r};
                instr_pc_d    = instr_pc_r + XLEN'(4);
                state_d       = RUN;
            end
`endif
            default: state_d = BOOT;
        endcase

        if (fetch_adv) begin
            blk_d = blk_r + BLK_STEP;
        end

        if (i_redirect_valid) begin
            o_instr_valid = 1'b0;
            state_d       = RUN;
            blk_d         = tgt_blk;
            instr_pc_d    = tgt_pc;
`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
            span_lo_d     = 16'h0;
`endif
        end else if (i_stall) begin
            state_d    = state_r;
            blk_d      = blk_r;
            instr_pc_d = instr_pc_r;
`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
            span_lo_d  = span_lo_r;
`endif
        end
    end

    // State, block address and instruction PC registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= BOOT;
            blk_r      <= RESET_VECTOR & BLK_MASK;
            instr_pc_r <= RESET_VECTOR & PC_MASK;
        end else begin
            state_r    <= state_d;
            blk_r      <= blk_d;
            instr_pc_r <= instr_pc_d;
        end
    end

`ifdef FROST_FETCH_SEQ_COMPRESSED_EN
    // Low half of an instruction straddling two fetch blocks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            span_lo_r <= 16'h0;
        end else begin
            span_lo_r <= span_lo_d;
        end
    end
`endif

endmodule
